// File: rtl/dmem_ctrl.sv
// Data-memory controller: in-order request FIFO from retire, bus issue with
// retry until accepted, tagged load tracking and load-data return.

module dmem_tag_entry #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_addr,
    input  logic            clear,
    output logic            valid,
    output logic [XLEN-1:0] addr
);
    // A same-cycle allocate beats the clear, so the entry stays live with the new load.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
        end else if (alloc) begin
            valid <= 1'b1;
            addr  <= alloc_addr;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end
endmodule

module dmem_ctrl #(
    parameter int DEPTH = 4,
    parameter int NTAGS = 16,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2Dmem_command,
    input  logic [XLEN-1:0] proc2Dmem_addr,
    input  logic [XLEN-1:0] proc2Dmem_data,
    output logic            dmem_ready,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic            Dmem2proc_valid,
    output logic [63:0]     Dmem2proc_data,
    output logic [XLEN-1:0] Dmem2proc_addr,
    output logic            idle
);
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam int         PW        = $clog2(DEPTH);
    localparam int         CW        = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0]      cmd;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } req_t;

    req_t            fifo [DEPTH];
    req_t            head;
    logic [PW-1:0]   head_ptr, tail_ptr;
    logic [CW-1:0]   count;
    logic            push, pop, nonempty, hit;

    logic [NTAGS-1:0]           tag_valid;
    logic [NTAGS-1:0][XLEN-1:0] tag_addr;
    logic [NTAGS-1:0]           tag_alloc;
    logic [NTAGS-1:0]           tag_clear;

    assign nonempty   = (count != '0);
    assign dmem_ready = (count < CW'(DEPTH));
    assign head       = fifo[head_ptr];
    assign push       = (proc2Dmem_command != BUS_NONE) && dmem_ready;
    assign pop        = nonempty && (mem2proc_response != '0);

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (nonempty) begin
            proc2mem_command = head.cmd;
            proc2mem_addr    = head.addr;
            proc2mem_data    = {{(64-XLEN){1'b0}}, head.data};
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo[tail_ptr] <= '{cmd: proc2Dmem_command, addr: proc2Dmem_addr,
                                data: proc2Dmem_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Tag 0 is never allocated (accept needs a nonzero response) and never hits.
    assign hit = (mem2proc_tag != '0) && tag_valid[mem2proc_tag];

    for (genvar i = 0; i < NTAGS; i++) begin : g_tag
        assign tag_alloc[i] = pop && (head.cmd == BUS_LOAD) && (mem2proc_response == 4'(i));
        assign tag_clear[i] = hit && (mem2proc_tag == 4'(i));
        dmem_tag_entry #(.XLEN(XLEN)) u_entry (
            .clock      (clock),
            .reset      (reset),
            .alloc      (tag_alloc[i]),
            .alloc_addr (head.addr),
            .clear      (tag_clear[i]),
            .valid      (tag_valid[i]),
            .addr       (tag_addr[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            Dmem2proc_valid <= 1'b0;
            Dmem2proc_data  <= '0;
            Dmem2proc_addr  <= '0;
        end else begin
            Dmem2proc_valid <= hit;
            if (hit) begin
                Dmem2proc_data <= mem2proc_data;
                Dmem2proc_addr <= tag_addr[mem2proc_tag];
            end
        end
    end

    assign idle = !nonempty && !(|tag_valid) && (proc2Dmem_command == BUS_NONE);
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: store, load, back-pressure, out-of-order,
// ignored tags, same-tag reuse and mid-operation reset.

module tb_dmem_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  proc2Dmem_command;
    logic [31:0] proc2Dmem_addr, proc2Dmem_data;
    logic        dmem_ready;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic        Dmem2proc_valid;
    logic [63:0] Dmem2proc_data;
    logic [31:0] Dmem2proc_addr;
    logic        idle;

    int n_chk = 0;
    int n_fail = 0;

    dmem_ctrl dut (
        .clock(clock), .reset(reset),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
        .proc2Dmem_data(proc2Dmem_data), .dmem_ready(dmem_ready),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .Dmem2proc_valid(Dmem2proc_valid), .Dmem2proc_data(Dmem2proc_data),
        .Dmem2proc_addr(Dmem2proc_addr), .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        proc2Dmem_command = c;
        proc2Dmem_addr    = a;
        proc2Dmem_data    = d;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_valid"}, 64'(Dmem2proc_valid), 64'd0);
        chk({pfx, "_ddata"}, Dmem2proc_data, 64'd0);
        chk({pfx, "_daddr"}, 64'(Dmem2proc_addr), 64'd0);
        chk({pfx, "_bcmd"},  64'(proc2mem_command), 64'd0);
        chk({pfx, "_baddr"}, 64'(proc2mem_addr), 64'd0);
        chk({pfx, "_bdata"}, proc2mem_data, 64'd0);
        chk({pfx, "_ready"}, 64'(dmem_ready), 64'd1);
        chk({pfx, "_idle"},  64'(idle), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        drive(2'd0, 32'h0, 32'h0);
        mem2proc_response = 4'd0;
        mem2proc_tag      = 4'd0;
        mem2proc_data     = 64'd0;
        tick(); tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Store accepted the cycle it is issued
        drive(2'd2, 32'h100, 32'hDEADBEEF);
        #1 chk("st_idle_cmd_in", 64'(idle), 64'd0);
        tick();
        drive(2'd0, 32'h0, 32'h0);
        mem2proc_response = 4'd3;
        #1;
        chk("st_bus_cmd",  64'(proc2mem_command), 64'd2);
        chk("st_bus_addr", 64'(proc2mem_addr), 64'h100);
        chk("st_bus_data", proc2mem_data, 64'h00000000DEADBEEF);
        tick();
        mem2proc_response = 4'd0;
        #1;
        chk("st_bus_gone", 64'(proc2mem_command), 64'd0);
        chk("st_no_valid", 64'(Dmem2proc_valid), 64'd0);
        chk("st_idle",     64'(idle), 64'd1);

        // Load with tag 5, data three cycles later
        drive(2'd1, 32'h208, 32'h0);
        tick();
        drive(2'd0, 32'h0, 32'h0);
        mem2proc_response = 4'd5;
        #1 chk("ld_bus_cmd", 64'(proc2mem_command), 64'd1);
        tick();
        mem2proc_response = 4'd0;
        #1 chk("ld_busy", 64'(idle), 64'd0);
        tick(); tick();
        mem2proc_tag  = 4'd5;
        mem2proc_data = 64'h1122334455667788;
        #1 chk("ld_not_yet", 64'(Dmem2proc_valid), 64'd0);
        tick();
        mem2proc_tag = 4'd0;
        #1;
        chk("ld_valid", 64'(Dmem2proc_valid), 64'd1);
        chk("ld_data",  Dmem2proc_data, 64'h1122334455667788);
        chk("ld_addr",  64'(Dmem2proc_addr), 64'h208);
        chk("ld_idle",  64'(idle), 64'd1);
        tick();
        chk("ld_pulse", 64'(Dmem2proc_valid), 64'd0);

        // Back-pressure: fill with response held at 0
        for (int i = 0; i < 4; i++) begin
            drive(2'd2, 32'(i * 8), 32'(i));
            #1 chk($sformatf("bp_ready%0d", i), 64'(dmem_ready), 64'd1);
            tick();
        end
        chk("bp_full", 64'(dmem_ready), 64'd0);
        drive(2'd2, 32'h20, 32'h55);
        tick();
        drive(2'd0, 32'h0, 32'h0);
        chk("bp_head_kept", 64'(proc2mem_addr), 64'h0);
        mem2proc_response = 4'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp_drain_addr%0d", i), 64'(proc2mem_addr), 64'(i * 8));
            chk($sformatf("bp_drain_data%0d", i), proc2mem_data, 64'(i));
            chk($sformatf("bp_drain_rdy%0d", i), 64'(dmem_ready), (i == 0) ? 64'd0 : 64'd1);
            tick();
        end
        mem2proc_response = 4'd0;
        #1;
        chk("bp_fifth_dropped", 64'(proc2mem_command), 64'd0);
        chk("bp_idle", 64'(idle), 64'd1);

        // Out-of-order completion; push of 0x80 overlaps accept of 0x40
        drive(2'd1, 32'h40, 32'h0);
        tick();
        drive(2'd1, 32'h80, 32'h0);
        mem2proc_response = 4'd1;
        tick();
        drive(2'd0, 32'h0, 32'h0);
        mem2proc_response = 4'd2;
        #1 chk("ooo_second_head", 64'(proc2mem_addr), 64'h80);
        tick();
        mem2proc_response = 4'd0;
        mem2proc_tag  = 4'd2;
        mem2proc_data = 64'hAAAA;
        tick();
        mem2proc_tag  = 4'd1;
        mem2proc_data = 64'hBBBB;
        #1;
        chk("ooo_v1", 64'(Dmem2proc_valid), 64'd1);
        chk("ooo_a1", 64'(Dmem2proc_addr), 64'h80);
        chk("ooo_d1", Dmem2proc_data, 64'hAAAA);
        tick();
        mem2proc_tag = 4'd0;
        #1;
        chk("ooo_v2", 64'(Dmem2proc_valid), 64'd1);
        chk("ooo_a2", 64'(Dmem2proc_addr), 64'h40);
        chk("ooo_d2", Dmem2proc_data, 64'hBBBB);
        tick();
        chk("ooo_done", 64'(Dmem2proc_valid), 64'd0);
        chk("ooo_idle", 64'(idle), 64'd1);

        // Store tag and stray tag are ignored
        drive(2'd2, 32'h300, 32'h1);
        tick();
        drive(2'd0, 32'h0, 32'h0);
        mem2proc_response = 4'd9;
        tick();
        mem2proc_response = 4'd0;
        mem2proc_tag = 4'd9;
        tick();
        mem2proc_tag = 4'd12;
        #1 chk("ign_store_tag", 64'(Dmem2proc_valid), 64'd0);
        tick();
        mem2proc_tag = 4'd0;
        #1;
        chk("ign_stray_tag", 64'(Dmem2proc_valid), 64'd0);
        chk("ign_idle", 64'(idle), 64'd1);

        // Same tag completes and is reallocated in one cycle
        drive(2'd1, 32'h700, 32'h0);
        tick();
        drive(2'd1, 32'h708, 32'h0);
        mem2proc_response = 4'd4;
        tick();
        drive(2'd0, 32'h0, 32'h0);
        mem2proc_tag  = 4'd4;
        mem2proc_data = 64'h77;
        tick();
        mem2proc_response = 4'd0;
        mem2proc_tag  = 4'd0;
        #1;
        chk("reuse_old_addr", 64'(Dmem2proc_addr), 64'h700);
        chk("reuse_still_busy", 64'(idle), 64'd0);
        mem2proc_tag  = 4'd4;
        mem2proc_data = 64'h78;
        tick();
        mem2proc_tag = 4'd0;
        #1;
        chk("reuse_new_valid", 64'(Dmem2proc_valid), 64'd1);
        chk("reuse_new_addr", 64'(Dmem2proc_addr), 64'h708);
        chk("reuse_idle", 64'(idle), 64'd1);

        // Reset with load outstanding on tag 7 and two queued stores
        drive(2'd1, 32'h500, 32'h0);
        tick();
        drive(2'd0, 32'h0, 32'h0);
        mem2proc_response = 4'd7;
        tick();
        mem2proc_response = 4'd0;
        drive(2'd2, 32'h600, 32'h2);
        tick();
        drive(2'd2, 32'h608, 32'h3);
        tick();
        drive(2'd0, 32'h0, 32'h0);
        chk("mid_queued", 64'(proc2mem_command), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("mid");
        mem2proc_tag  = 4'd7;
        mem2proc_data = 64'h99;
        tick();
        mem2proc_tag = 4'd0;
        #1 chk("mid_tag7_ignored", 64'(Dmem2proc_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid_no_issue%0d", i), 64'(proc2mem_command), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
